// File: rtl/pad_in_filter_pkg.sv
// Shared types and constants for the pad input conditioning bank.
// Per-pad edge events are carried as a small packed struct.
package pad_in_filter_pkg;

  localparam int unsigned DefCntWidth = 4;
  localparam int unsigned SyncStages  = 2;

  typedef logic [DefCntWidth-1:0] cnt_t;

  typedef struct packed {
    logic rise;
    logic fall;
  } pad_evt_t;

  // Edge classification between the current and the next filtered value.
  function automatic pad_evt_t edge_of(input logic cur, input logic nxt);
    pad_evt_t evt;
    evt.rise = ~cur & nxt;
    evt.fall = cur & ~nxt;
    return evt;
  endfunction

endpackage

// File: rtl/pad_in_filter_bit.sv
// One pad: input gating, 2-flop synchronizer, optional debounce counter,
// registered rise/fall pulses and sticky write-1-clear event status.
module pad_in_filter_bit
  import pad_in_filter_pkg::*;
#(
  parameter int unsigned CntWidth = DefCntWidth,
  parameter logic        ResetVal = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                pad_in_i,
  input  logic                pad_ie_i,
  input  logic                filt_en_i,
  input  logic [CntWidth-1:0] thresh_i,
  input  logic                evt_clr_i,
  output logic                filt_o,
  output logic                rise_o,
  output logic                fall_o,
  output logic                rise_sts_o,
  output logic                fall_sts_o
);

  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  logic                  gated;
  logic [SyncStages-1:0] sync_q;
  logic                  sync_out;

  logic                  filt_q, filt_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [CntWidth-1:0]   thr_eff;
  logic [CntWidth-1:0]   thr_last;

  pad_evt_t              evt_q, evt_d;
  pad_evt_t              sts_q, sts_d;

  // Gate before the first flop so a disabled (floating) pad reads a clean 0.
  assign gated    = pad_in_i & pad_ie_i;
  assign sync_out = sync_q[SyncStages-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SyncStages{ResetVal}};
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], gated};
    end
  end

  // A threshold of 0 behaves as 1; compare against T-1 so the update
  // lands on the T-th consecutive differing sample.
  assign thr_eff  = (thresh_i == '0) ? CntOne : thresh_i;
  assign thr_last = thr_eff - CntOne;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (!filt_en_i) begin
      filt_d = sync_out;
      cnt_d  = '0;
    end else if (sync_out == filt_q) begin
      cnt_d  = '0;
    end else if (cnt_q >= thr_last) begin
      filt_d = sync_out;
      cnt_d  = '0;
    end else begin
      cnt_d  = cnt_q + CntOne;
    end
  end

  always_comb begin
    evt_d      = edge_of(filt_q, filt_d);
    // An event arriving with a clear keeps the status set.
    sts_d.rise = (sts_q.rise & ~evt_clr_i) | evt_d.rise;
    sts_d.fall = (sts_q.fall & ~evt_clr_i) | evt_d.fall;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q <= ResetVal;
      cnt_q  <= '0;
      evt_q  <= '0;
      sts_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      evt_q  <= evt_d;
      sts_q  <= sts_d;
    end
  end

  assign filt_o     = filt_q;
  assign rise_o     = evt_q.rise;
  assign fall_o     = evt_q.fall;
  assign rise_sts_o = sts_q.rise;
  assign fall_sts_o = sts_q.fall;

endmodule

// File: rtl/pad_in_filter.sv
// Bank of independent pad input conditioners sharing a single debounce
// threshold; each pad is one pad_in_filter_bit instance.
module pad_in_filter
  import pad_in_filter_pkg::*;
#(
  parameter int unsigned NumPads  = 8,
  parameter int unsigned CntWidth = DefCntWidth,
  parameter logic        ResetVal = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumPads-1:0]  pad_in_i,
  input  logic [NumPads-1:0]  pad_ie_i,
  input  logic [NumPads-1:0]  filt_en_i,
  input  logic [CntWidth-1:0] thresh_i,
  input  logic [NumPads-1:0]  evt_clr_i,
  output logic [NumPads-1:0]  filt_o,
  output logic [NumPads-1:0]  rise_o,
  output logic [NumPads-1:0]  fall_o,
  output logic [NumPads-1:0]  rise_sts_o,
  output logic [NumPads-1:0]  fall_sts_o
);

  for (genvar i = 0; i < NumPads; i++) begin : g_pad
    pad_in_filter_bit #(
      .CntWidth (CntWidth),
      .ResetVal (ResetVal)
    ) u_bit (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .pad_in_i   (pad_in_i[i]),
      .pad_ie_i   (pad_ie_i[i]),
      .filt_en_i  (filt_en_i[i]),
      .thresh_i   (thresh_i),
      .evt_clr_i  (evt_clr_i[i]),
      .filt_o     (filt_o[i]),
      .rise_o     (rise_o[i]),
      .fall_o     (fall_o[i]),
      .rise_sts_o (rise_sts_o[i]),
      .fall_sts_o (fall_sts_o[i])
    );
  end

endmodule
